// File: rtl/vga_image_viewer.sv
// vga_image_viewer: image-window engine between vga_sync and a synchronous
// image ROM. Shows one of NUM_IMG images (IMG_W x IMG_H, upscaled by SCALE)
// centred on a 640x480 screen through a two-stage, sync-aligned pixel
// pipeline. A slideshow controller (MANUAL / AUTO) changes the displayed
// image only at a frame boundary, so a frame never mixes two images.
//
// Optional build macro: VGA_IMAGE_VIEWER_BORDER_EN
//   defined   -> the 2-pixel ring just outside the window is painted 12'hFFF
//   undefined -> the ring is black and no border logic exists
//
// Handshake: there is no valid/ready pair here. p_tick is a one-clk enable
// from vga_sync; every pixel-path register advances only when p_tick=1, and
// rom_data is consumed one p_tick after rom_addr (at least 2 clks later,
// so the ROM's 1-clk read latency is always covered).
module vga_image_viewer #(
  parameter int IMG_W          = 160,
  parameter int IMG_H          = 120,
  parameter int SCALE          = 2,
  parameter int NUM_IMG        = 4,
  parameter int ADDR_W         = 20,
  parameter int FRAMES_PER_IMG = 120,
  localparam int SEL_W         = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_tick,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [SEL_W-1:0]  sel,
  input  logic              auto_en,
  input  logic              next,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic              hsync,
  output logic              vsync,
  output logic [11:0]       rgb,
  output logic [SEL_W-1:0]  img_idx
);

  // Window geometry, all compile-time constants.
  localparam int WIN_W   = IMG_W * SCALE;
  localparam int WIN_H   = IMG_H * SCALE;
  localparam int X0      = (640 - WIN_W) / 2;
  localparam int X1      = X0 + WIN_W;
  localparam int Y0      = (480 - WIN_H) / 2;
  localparam int Y1      = Y0 + WIN_H;
  // Column counters restart on the pixel just left of the window; a
  // full-width window has no such pixel, so restart at the end of the line.
  localparam int CLR_X   = (X0 > 0) ? X0 - 1 : 799;
  localparam int IMG_PIX = IMG_W * IMG_H;
  localparam int SUB_W   = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int CNT_W   = (FRAMES_PER_IMG > 1) ? $clog2(FRAMES_PER_IMG) : 1;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_t;

  mode_t              state;
  mode_t              state_n;
  logic [SEL_W-1:0]   idx_n;
  logic [SEL_W-1:0]   sel_clamp;
  logic [CNT_W-1:0]   frame_cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic               next_pend;
  logic               pend_clr;

  logic               in_win;
  logic               frame_start;
  logic               last_win_px;

  logic [SUB_W-1:0]   sub_x;
  logic [ADDR_W-1:0]  col;
  logic [SUB_W-1:0]   sub_y;
  logic [ADDR_W-1:0]  row_base;
  logic [ADDR_W-1:0]  img_base_n;

  logic               in_win_d1;
  logic               video_on_d1;
  logic               hsync_d1;
  logic               vsync_d1;

  // Window membership, frame boundary and end-of-window-line decode.
  always_comb begin
    in_win      = (x >= 10'(X0)) && (x < 10'(X1)) &&
                  (y >= 10'(Y0)) && (y < 10'(Y1));
    frame_start = p_tick && (x == 10'd0) && (y == 10'd480);
    last_win_px = in_win && (x == 10'(X1 - 1));
  end

  // Clamp the manual selector to the last stored image.
  always_comb begin
    if ({1'b0, sel} >= (SEL_W + 1)'(NUM_IMG)) begin
      sel_clamp = SEL_W'(NUM_IMG - 1);
    end else begin
      sel_clamp = sel;
    end
  end

  // Slideshow next-state logic; only a frame boundary can change anything.
  always_comb begin
    state_n  = state;
    idx_n    = img_idx;
    cnt_n    = frame_cnt;
    pend_clr = 1'b0;
    if (frame_start) begin
      case (state)
        MANUAL: begin
          pend_clr = 1'b1;
          if (auto_en) begin
            state_n = AUTO;
            cnt_n   = '0;
          end else begin
            idx_n = sel_clamp;
          end
        end
        AUTO: begin
          if (!auto_en) begin
            state_n = MANUAL;
            idx_n   = sel_clamp;
          end else if ((frame_cnt == CNT_W'(FRAMES_PER_IMG - 1)) || next_pend) begin
            idx_n    = (img_idx == SEL_W'(NUM_IMG - 1)) ? '0 : img_idx + SEL_W'(1);
            cnt_n    = '0;
            pend_clr = 1'b1;
          end else begin
            cnt_n = frame_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_n = MANUAL;
        end
      endcase
    end
  end

  // Slideshow state register: mode, displayed image and frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MANUAL;
      img_idx   <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      img_idx   <= idx_n;
      frame_cnt <= cnt_n;
    end
  end

  // Pending 'next' request; a new pulse wins over a same-clk clear so a
  // pulse coinciding with a frame boundary is honoured at the following one.
  always_ff @(posedge clk) begin
    if (reset) begin
      next_pend <= 1'b0;
    end else if (next) begin
      next_pend <= 1'b1;
    end else if (pend_clr) begin
      next_pend <= 1'b0;
    end
  end

  // Base address of the image about to be shown (constant multiplier,
  // only consumed at a frame boundary).
  always_comb begin
    img_base_n = ADDR_W'(idx_n) * ADDR_W'(IMG_PIX);
  end

  // Column counter: SCALE screen pixels per source column.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_x <= '0;
      col   <= '0;
    end else if (p_tick) begin
      if (x == 10'(CLR_X)) begin
        sub_x <= '0;
        col   <= '0;
      end else if (in_win) begin
        if (sub_x == SUB_W'(SCALE - 1)) begin
          sub_x <= '0;
          col   <= col + ADDR_W'(1);
        end else begin
          sub_x <= sub_x + SUB_W'(1);
        end
      end
    end
  end

  // Row counter: SCALE window lines per source row, row_base steps by IMG_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_y    <= '0;
      row_base <= '0;
    end else if (p_tick) begin
      if (frame_start) begin
        sub_y    <= '0;
        row_base <= img_base_n;
      end else if (last_win_px) begin
        if (sub_y == SUB_W'(SCALE - 1)) begin
          sub_y    <= '0;
          row_base <= row_base + ADDR_W'(IMG_W);
        end else begin
          sub_y <= sub_y + SUB_W'(1);
        end
      end
    end
  end

  // Stage 1: issue the ROM address and delay the qualifiers and syncs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr    <= '0;
      in_win_d1   <= 1'b0;
      video_on_d1 <= 1'b0;
      hsync_d1    <= 1'b0;
      vsync_d1    <= 1'b0;
    end else if (p_tick) begin
      rom_addr    <= in_win ? (row_base + col) : '0;
      in_win_d1   <= in_win;
      video_on_d1 <= video_on;
      hsync_d1    <= hsync_in;
      vsync_d1    <= vsync_in;
    end
  end

`ifdef VGA_IMAGE_VIEWER_BORDER_EN
  logic ring;
  logic ring_d1;

  // Ring = 2-pixel band around the window, excluding the window itself.
  always_comb begin
    ring = ({1'b0, x} + 11'd2 >= 11'(X0)) && ({1'b0, x} < 11'(X1 + 2)) &&
           ({1'b0, y} + 11'd2 >= 11'(Y0)) && ({1'b0, y} < 11'(Y1 + 2)) &&
           !in_win;
  end

  // Delay the ring flag alongside the other stage-1 qualifiers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ring_d1 <= 1'b0;
    end else if (p_tick) begin
      ring_d1 <= ring;
    end
  end

  // Stage 2: window shows ROM data, ring shows white, everything else black.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb   <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else if (p_tick) begin
      if (video_on_d1 && in_win_d1) begin
        rgb <= rom_data;
      end else if (video_on_d1 && ring_d1) begin
        rgb <= 12'hFFF;
      end else begin
        rgb <= '0;
      end
      hsync <= hsync_d1;
      vsync <= vsync_d1;
    end
  end
`else
  // Stage 2: window shows ROM data, everything else black.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb   <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else if (p_tick) begin
      rgb   <= (video_on_d1 && in_win_d1) ? rom_data : '0;
      hsync <= hsync_d1;
      vsync <= vsync_d1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_image_viewer.sv
// Directed bench for vga_image_viewer. Three instances share the scan
// inputs: 'a' uses default parameters, 'b' has FRAMES_PER_IMG=3 for the
// slideshow sequence, 'c' has NUM_IMG=3 for selector clamping.
module tb_vga_image_viewer;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [1:0]  sel;
  logic        auto_en_a;
  logic        auto_en_b;
  logic        next;

  logic [19:0] a_addr, b_addr, c_addr;
  logic [11:0] a_data, b_data, c_data;
  logic [11:0] a_rgb, b_rgb, c_rgb;
  logic        a_hs, b_hs, c_hs;
  logic        a_vs, b_vs, c_vs;
  logic [1:0]  a_idx, b_idx, c_idx;

  int total = 0;
  int bad   = 0;

  // Clock / reset block.
  always #5 clk = ~clk;

  vga_image_viewer u_a (
    .clk(clk), .reset(reset), .p_tick(p_tick), .x(x), .y(y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .sel(sel), .auto_en(auto_en_a), .next(next), .rom_addr(a_addr),
    .rom_data(a_data), .hsync(a_hs), .vsync(a_vs), .rgb(a_rgb),
    .img_idx(a_idx)
  );

  vga_image_viewer #(.FRAMES_PER_IMG(3)) u_b (
    .clk(clk), .reset(reset), .p_tick(p_tick), .x(x), .y(y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .sel(sel), .auto_en(auto_en_b), .next(next), .rom_addr(b_addr),
    .rom_data(b_data), .hsync(b_hs), .vsync(b_vs), .rgb(b_rgb),
    .img_idx(b_idx)
  );

  vga_image_viewer #(.NUM_IMG(3), .FRAMES_PER_IMG(3)) u_c (
    .clk(clk), .reset(reset), .p_tick(p_tick), .x(x), .y(y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .sel(sel), .auto_en(auto_en_a), .next(next), .rom_addr(c_addr),
    .rom_data(c_data), .hsync(c_hs), .vsync(c_vs), .rgb(c_rgb),
    .img_idx(c_idx)
  );

  // ROM content model: a fixed scramble of the address.
  function automatic logic [11:0] rom_fn(input logic [19:0] ad);
    return ad[11:0] ^ ad[19:8] ^ 12'h5A3;
  endfunction

  // Synchronous ROMs, 1-clk read latency.
  always @(posedge clk) begin
    a_data <= rom_fn(a_addr);
    b_data <= rom_fn(b_addr);
    c_data <= rom_fn(c_addr);
  end

  // Scoreboard check: one comparison, counted and reported.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: present one pixel with a p_tick, then one idle clk.
  task automatic tick(input logic [9:0] tx, input logic [9:0] ty,
                      input logic tvo, input logic ths, input logic tvs,
                      input logic tnx);
    x        = tx;
    y        = ty;
    video_on = tvo;
    hsync_in = ths;
    vsync_in = tvs;
    next     = tnx;
    p_tick   = 1'b1;
    @(posedge clk);
    #1;
    p_tick = 1'b0;
    next   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Driver: frame boundary pixel (x=0, y=480).
  task automatic fs(input logic tnx);
    tick(10'd0, 10'd480, 1'b0, 1'b1, 1'b0, tnx);
  endtask

  // Driver: one-clk next pulse away from any p_tick.
  task automatic pulse_next();
    next = 1'b1;
    @(posedge clk);
    #1;
    next = 1'b0;
  endtask

  logic [1:0]  auto_seq [13] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1,
                                 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
  logic [11:0] border_exp;

  initial begin
`ifdef VGA_IMAGE_VIEWER_BORDER_EN
    border_exp = 12'hFFF;
`else
    border_exp = 12'h000;
`endif
    reset = 1'b1; p_tick = 1'b0; x = '0; y = '0; video_on = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; sel = 2'd0; auto_en_a = 1'b0;
    auto_en_b = 1'b0; next = 1'b0;
    @(posedge clk);
    #1;

    // Reset held during active video.
    tick(10'd200, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(10'd201, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_rgb", 32'(a_rgb), 0);
    chk("rst_hsync", 32'(a_hs), 0);
    chk("rst_vsync", 32'(a_vs), 0);
    chk("rst_idx", 32'(a_idx), 0);
    chk("rst_addr", 32'(a_addr), 0);
    reset = 1'b0;

    // First window pixel after reset.
    tick(10'd159, 10'd120, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(10'd160, 10'd120, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("first_addr", 32'(a_addr), 0);
    tick(10'd161, 10'd120, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("first_rgb", 32'(a_rgb), 32'(rom_fn(20'd0)));
    tick(10'd162, 10'd120, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("first_col1_addr", 32'(a_addr), 1);

    // Manual select of image 2 and address walk.
    sel = 2'd2;
    fs(1'b0);
    chk("sel2_idx", 32'(a_idx), 2);
    tick(10'd479, 10'd120, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(10'd159, 10'd121, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(10'd160, 10'd121, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(10'd161, 10'd121, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("addr_161_121", 32'(a_addr), 38400);
    tick(10'd479, 10'd121, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rgb_161_121", 32'(a_rgb), 32'(rom_fn(20'd38400)));
    tick(10'd159, 10'd122, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(10'd160, 10'd122, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(10'd161, 10'd122, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(10'd162, 10'd122, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("addr_162_122", 32'(a_addr), 38561);
    for (int yy = 122; yy <= 358; yy++) begin
      tick(10'd479, 10'(yy), 1'b1, 1'b1, 1'b1, 1'b0);
    end
    tick(10'd159, 10'd359, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int xx = 160; xx <= 479; xx++) begin
      tick(10'(xx), 10'd359, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    chk("addr_last", 32'(a_addr), 57599);
    tick(10'd480, 10'd359, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rgb_last", 32'(a_rgb), 32'(rom_fn(20'd57599)));
    chk("addr_right_of_win", 32'(a_addr), 0);

    // Outside window and blanking; syncs delayed by exactly two ticks.
    tick(10'd100, 10'd200, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("out_addr", 32'(a_addr), 0);
    chk("sync_d2_h_a", 32'(a_hs), 1);
    tick(10'd700, 10'd200, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("out_rgb", 32'(a_rgb), 0);
    chk("sync_d2_h_b", 32'(a_hs), 0);
    chk("sync_d2_v_b", 32'(a_vs), 1);
    tick(10'd701, 10'd200, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("blank_rgb", 32'(a_rgb), 0);
    chk("blank_addr", 32'(a_addr), 0);
    chk("sync_d2_h_c", 32'(a_hs), 1);
    chk("sync_d2_v_c", 32'(a_vs), 0);

    // Border ring at the left edge of the window.
    fs(1'b0);
    tick(10'd158, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(10'd159, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("ring_158", 32'(a_rgb), 32'(border_exp));
    tick(10'd160, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("ring_159", 32'(a_rgb), 32'(border_exp));
    chk("win_160_addr", 32'(a_addr), 38400);
    tick(10'd161, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("win_160_rgb", 32'(a_rgb), 32'(rom_fn(20'd38400)));

    // Manual mode: sel change waits for frame boundary, next ignored.
    sel = 2'd1;
    tick(10'd300, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("no_tear_idx", 32'(a_idx), 2);
    pulse_next();
    tick(10'd300, 10'd201, 1'b1, 1'b1, 1'b1, 1'b0);
    fs(1'b0);
    chk("manual_next_idx", 32'(a_idx), 1);
    sel = 2'd3;
    fs(1'b0);
    chk("sel3_idx_a", 32'(a_idx), 3);
    chk("sel3_clamp_c", 32'(c_idx), 2);

    // Auto slideshow, three frames per image.
    sel = 2'd0;
    fs(1'b0);
    chk("auto_start_idx", 32'(b_idx), 0);
    auto_en_b = 1'b1;
    for (int i = 0; i < 13; i++) begin
      fs(1'b0);
      chk($sformatf("auto_fs%0d", i), 32'(b_idx), 32'(auto_seq[i]));
      tick(10'd300, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);
      chk($sformatf("auto_mid%0d", i), 32'(b_idx), 32'(auto_seq[i]));
    end

    // next in auto mode: advances at the next boundary, counter restarts.
    fs(1'b0);
    chk("next_fs_a", 32'(b_idx), 0);
    pulse_next();
    tick(10'd300, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("next_mid", 32'(b_idx), 0);
    fs(1'b0);
    chk("next_adv", 32'(b_idx), 1);
    fs(1'b0);
    chk("next_cnt1", 32'(b_idx), 1);
    fs(1'b0);
    chk("next_cnt2", 32'(b_idx), 1);
    fs(1'b0);
    chk("next_wrapcnt", 32'(b_idx), 2);
    // next on the same clk as a frame boundary is used one frame later.
    fs(1'b1);
    chk("next_same_clk", 32'(b_idx), 2);
    fs(1'b0);
    chk("next_deferred", 32'(b_idx), 3);

    // Reset mid-frame.
    tick(10'd300, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(10'd301, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_idx_b", 32'(b_idx), 0);
    chk("midrst_rgb", 32'(a_rgb), 0);
    chk("midrst_addr", 32'(a_addr), 0);
    chk("midrst_hsync", 32'(a_hs), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_image_viewer.md
Name: vga_image_viewer

Overview:
- Parametrised image-window engine between vga_sync and a synchronous image ROM.
- Holds NUM_IMG images of IMG_W x IMG_H pixels, upscaled by SCALE and centred on the 640x480 screen.
- Adds a registered, sync-aligned pixel pipeline and multiplier-free address counters.
- Adds a manual/auto slideshow controller whose image changes only at a frame boundary.

Parameters:
IMG_W, 160, source image width in pixels
IMG_H, 120, source image height in pixels
SCALE, 2, integer upscale factor, applied to both axes (1..8)
NUM_IMG, 4, number of images stored back-to-back in ROM
ADDR_W, 20, ROM address width; must hold NUM_IMG*IMG_W*IMG_H
FRAMES_PER_IMG, 120, frames each image is shown in auto mode

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
p_tick  in  1  pixel enable from vga_sync; at least 2 clk periods apart
x  in  10  current pixel column from vga_sync
y  in  10  current pixel row from vga_sync
video_on  in  1  visible-area flag from vga_sync
hsync_in  in  1  raw hsync from vga_sync
vsync_in  in  1  raw vsync from vga_sync
sel  in  $clog2(NUM_IMG)  manual image select
auto_en  in  1  1 = slideshow mode
next  in  1  one-clk pulse: advance image (auto mode only)
rom_addr  out  ADDR_W  registered ROM address
rom_data  in  12  ROM read data, valid 1 clk after rom_addr
hsync  out  1  hsync delayed to match rgb
vsync  out  1  vsync delayed to match rgb
rgb  out  12  registered pixel colour
img_idx  out  $clog2(NUM_IMG)  image currently displayed

Behaviour:
- Reset values: rom_addr=0, rgb=0, hsync=0, vsync=0, img_idx=0, state=MANUAL, frame counter=0, next_pend=0, all pipeline registers 0.
- Window geometry: X0=(640-IMG_W*SCALE)/2, Y0=(480-IMG_H*SCALE)/2. in_win = X0<=x<X0+IMG_W*SCALE and Y0<=y<Y0+IMG_H*SCALE.
- Registers update only on p_tick.
- Stage 1:
  - rom_addr <= in_win ? row_base+col : 0.
  - Register in_win, video_on, hsync_in and vsync_in into the d1 stage.
- Stage 2:
  - rgb <= (video_on_d1 && in_win_d1) ? rom_data : 0.
  - hsync <= hsync_d1; vsync <= vsync_d1.
- Total latency from x/y to rgb is 2 p_ticks; syncs delayed identically.
- Column counter:
  - sub_x and col clear when x==X0-1.
  - Inside the window, sub_x counts 0..SCALE-1; col increments when sub_x wraps.
- Row counter:
  - frame_start = p_tick && x==0 && y==480.
  - At frame_start: row_base <= img_base(new idx), sub_y <= 0.
  - On the last window pixel of each window line, sub_y increments. When sub_y==SCALE-1, row_base += IMG_W and sub_y <= 0.
  - No multiply or divide on x/y paths. img_base = idx*IMG_W*IMG_H, evaluated only at frame_start.
- Slideshow FSM, states MANUAL and AUTO, evaluated only at frame_start:
  - MANUAL: img_idx <= min(sel, NUM_IMG-1). next_pend is cleared. If auto_en=1, go to AUTO, keep img_idx, frame counter=0.
  - AUTO, auto_en=0: go to MANUAL, img_idx <= min(sel, NUM_IMG-1).
  - AUTO, counter==FRAMES_PER_IMG-1 or next_pend=1: img_idx increments, wrapping NUM_IMG-1 -> 0. Counter <= 0, next_pend <= 0.
  - AUTO otherwise: counter++.
- next handling:
  - next sets next_pend on any clk, in either state.
  - A next pulse on the same clk as frame_start is consumed at the following frame_start.
- img_idx never changes mid-frame, so there is no tearing.
- Reset asserted mid-frame: all state returns to reset values on the next clk; rgb=0 until the pipeline refills.

Optional Feature:
- Macro: VGA_IMAGE_VIEWER_BORDER_EN.
- Defined: pixels with video_on_d1=1 lying in the 2-pixel ring just outside the window output 12'hFFF in stage 2. Window interior is unchanged.
- Undefined: the ring outputs 0, and no border logic is synthesised.

Test Plan:
- Reset held 3 clk during active video -> rgb=0, hsync=vsync=0, img_idx=0, rom_addr=0; after release, first window pixel (x=160,y=120, defaults) drives rom_addr=0 and rgb=rom_data 2 p_ticks later.
- sel=2, auto_en=0, scan one frame -> img_idx=2 after frame_start. Pixel (x=161,y=121) gives addr 38400; (x=162,y=122) gives 38561; last window pixel (479,359) gives 57599.
- Outside-window pixels (x=100,y=200) and blanking (x=700) -> rgb=0, rom_addr=0; hsync/vsync equal the inputs delayed exactly 2 p_ticks.
- auto_en=1, FRAMES_PER_IMG=3 -> img_idx sequence 0,0,0,1,1,1,2,2,2,3,3,3,0 across frames; never changes between frame_starts.
- AUTO mode, next pulse mid-frame -> img_idx advances at the next frame_start and the counter restarts. next pulse in MANUAL -> no effect. sel=3 with NUM_IMG=3 -> img_idx clamps to 2.
- With VGA_IMAGE_VIEWER_BORDER_EN -> pixel (158,200) outputs 12'hFFF and (160,200) shows ROM data. Without the macro -> (158,200) outputs 0.
